// File: rtl/ox_train_seq.sv
// Training sequencer for the O/X MLP classifier: replays a labelled 4x4 pattern buffer,
// pulses learn on each misclassification and repeats epochs until clean or out of budget.
module ox_train_seq #(
  parameter int  NS        = 8,
  parameter int  MAX_EPOCH = 32,
  parameter int  SETTLE    = 2,
  localparam int IW        = $clog2(NS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [15:0]   wr_pattern,
  input  logic          wr_label,
  input  logic          y,
  output logic [15:0]   x,
  output logic          is_O,
  output logic          learn,
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic [7:0]    epoch_cnt,
  output logic [IW:0]   err_cnt
);
  localparam int          SW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IW:0] ERR_MAX = (IW+1)'(NS);
  localparam logic [7:0]  EP_MAX  = 8'(MAX_EPOCH);

  typedef enum logic [2:0] {
    S_IDLE, S_PRESENT, S_JUDGE, S_LEARN, S_EPOCH_END, S_DONE
  } state_e;

  typedef struct packed {
    logic        label;
    logic [15:0] pattern;
  } sample_t;

  state_e        state_q, state_d, adv_state;
  sample_t       smp_q [NS];
  sample_t       smp_d [NS];
  sample_t       cur;
  logic [IW-1:0] idx_q, idx_d, adv_idx;
  logic [SW-1:0] set_q, set_d;
  logic [IW:0]   run_err_q, run_err_d, err_cnt_q, err_cnt_d;
  logic [7:0]    epoch_q, epoch_d, epoch_inc;
  logic          conv_q, conv_d;
  logic          last;
  logic          presenting;

  assign cur        = smp_q[idx_q];
  assign last       = (idx_q == IW'(NS - 1));
  assign presenting = state_q inside {S_PRESENT, S_JUDGE, S_LEARN};

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    set_d     = set_q;
    run_err_d = run_err_q;
    err_cnt_d = err_cnt_q;
    epoch_d   = epoch_q;
    conv_d    = conv_q;
    smp_d     = smp_q;
    epoch_inc = (epoch_q == EP_MAX) ? epoch_q : epoch_q + 8'd1;
    adv_state = last ? S_EPOCH_END : S_PRESENT;
    adv_idx   = last ? idx_q : idx_q + IW'(1);

    if (wr_en && !busy && (32'(wr_addr) < NS)) begin
      smp_d[wr_addr] = '{label: wr_label, pattern: wr_pattern};
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_PRESENT;
          idx_d     = '0;
          set_d     = '0;
          epoch_d   = '0;
          run_err_d = '0;
          conv_d    = 1'b0;
        end
      end
      S_PRESENT: begin
        if (set_q == SW'(SETTLE - 1)) state_d = S_JUDGE;
        else                          set_d   = set_q + SW'(1);
      end
      S_JUDGE: begin
        set_d = '0;
        if (y != cur.label) begin
          if (run_err_q != ERR_MAX) run_err_d = run_err_q + (IW+1)'(1);
          state_d = S_LEARN;
        end else begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end
      end
      S_LEARN: begin
        state_d = adv_state;
        idx_d   = adv_idx;
      end
      S_EPOCH_END: begin
        epoch_d   = epoch_inc;
        err_cnt_d = run_err_q;
        run_err_d = '0;
        if (run_err_q == '0) begin
          state_d = S_DONE;
          conv_d  = 1'b1;
        end else if (epoch_inc == EP_MAX) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PRESENT;
          idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      set_q     <= '0;
      run_err_q <= '0;
      err_cnt_q <= '0;
      epoch_q   <= '0;
      conv_q    <= 1'b0;
      // NOTE: the buffer is a small register file, not a RAM macro, so it resets like other state.
      for (int i = 0; i < NS; i++) smp_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values together.
      state_q   <= state_d;
      idx_q     <= idx_d;
      set_q     <= set_d;
      run_err_q <= run_err_d;
      err_cnt_q <= err_cnt_d;
      epoch_q   <= epoch_d;
      conv_q    <= conv_d;
      smp_q     <= smp_d;
    end
  end

  assign x         = presenting ? cur.pattern : 16'h0000;
  assign is_O      = presenting & cur.label;
  assign learn     = (state_q == S_LEARN);
  assign busy      = presenting | (state_q == S_EPOCH_END);
  assign done      = (state_q == S_DONE);
  assign converged = conv_q;
  assign epoch_cnt = epoch_q;
  assign err_cnt   = err_cnt_q;
endmodule
